// File: rtl/mat_mul_check.sv
// N x N fixed-point C = A x B with one shared MAC; each C element takes N+1 cycles, first out_valid N cycles after the last input edge.
// C elements stall in OUT indefinitely under out_ready=0 without loss; in_ready is high only while loading.
module mat_mul_check #(
  parameter int N    = 5,
  parameter int DW   = 32,
  parameter int FRAC = 16,
  parameter int TOL  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          is_identity,
  output logic          busy
);

  localparam int NN   = N * N;
  localparam int CW   = $clog2(N);
  localparam int AW   = $clog2(NN);
  localparam int LW   = $clog2(2 * NN);
  localparam int PW   = 2 * DW;
  localparam int ACCW = PW + CW;
  localparam int DW1  = DW + 1;

  localparam logic [LW-1:0] LAST_WORD = LW'(2 * NN - 1);
  localparam logic [CW-1:0] KMAX      = CW'(N - 1);
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] ONE  = {{(DW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;
  state_t state, state_nxt;

  logic [LW-1:0] load_cnt;
  logic [CW-1:0] row, col, k;
  logic signed [ACCW-1:0] acc;
  logic id_ok;

  logic signed [DW-1:0] a_mem [NN];
  logic signed [DW-1:0] b_mem [NN];

  logic                   load_hs, elem_last, elem_bad;
  logic [AW-1:0]          a_addr, b_addr, wb_addr;
  logic [LW-1:0]          wb_off;
  logic signed [DW-1:0]   a_el, b_el;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] sum, shifted;
  logic [DW-1:0]          res, exp_val;
  logic [DW:0]            diff, adiff;

  assign elem_last = (row == KMAX) && (col == KMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load_hs   = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        load_hs  = in_valid;
        if (in_valid && load_cnt == LAST_WORD) state_nxt = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (k == KMAX) state_nxt = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = elem_last ? S_LOAD : S_MAC;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  assign out_last    = out_valid && elem_last;
  assign is_identity = out_valid && id_ok;

  // Final sum is scaled back to Q format, clamped, then checked against I.
  always_comb begin
    a_addr  = AW'(row) * AW'(N) + AW'(k);
    b_addr  = AW'(k) * AW'(N) + AW'(col);
    wb_off  = load_cnt - LW'(NN);
    wb_addr = AW'(wb_off);
    a_el    = a_mem[a_addr];
    b_el    = b_mem[b_addr];
    prod    = PW'(a_el) * PW'(b_el);
    sum     = acc + ACCW'(prod);
    shifted = sum >>> FRAC;
    if (shifted > SMAX)      res = DMAX;
    else if (shifted < SMIN) res = DMIN;
    else                     res = shifted[DW-1:0];
    exp_val  = (row == col) ? ONE : '0;
    diff     = {res[DW-1], res} - {exp_val[DW-1], exp_val};
    adiff    = diff[DW] ? (~diff + DW1'(1)) : diff;
    elem_bad = adiff > DW1'(TOL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt <= '0;
      row      <= '0;
      col      <= '0;
      k        <= '0;
      acc      <= '0;
      out_data <= '0;
      id_ok    <= 1'b1;
    end else begin
      case (state)
        S_LOAD: if (load_hs) begin
          if (load_cnt == LAST_WORD) begin
            load_cnt <= '0;
            row      <= '0;
            col      <= '0;
            k        <= '0;
            acc      <= '0;
            id_ok    <= 1'b1;
          end else begin
            load_cnt <= load_cnt + LW'(1);
          end
        end
        S_MAC: begin
          if (k == KMAX) begin
            out_data <= res;
            if (elem_bad) id_ok <= 1'b0;
          end else begin
            acc <= sum;
            k   <= k + CW'(1);
          end
        end
        S_OUT: if (out_ready) begin
          if (elem_last) begin
            load_cnt <= '0;
          end else begin
            if (col == KMAX) begin
              col <= '0;
              row <= row + CW'(1);
            end else begin
              col <= col + CW'(1);
            end
            k   <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Matrix storage is not reset; every load rewrites all of it.
  always_ff @(posedge clk) begin
    if (rst_n && load_hs) begin
      if (load_cnt < LW'(NN)) a_mem[load_cnt[AW-1:0]] <= in_data;
      else                    b_mem[wb_addr]          <= in_data;
    end
  end

endmodule

// File: tb/tb_mat_mul_check.sv
// Directed bench for mat_mul_check: identity, pass-through, saturation, sign, timing, stall and mid-run reset.
module tb_mat_mul_check;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_last, is_identity, busy;
  logic [31:0] in_data, out_data;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t_in;

  logic [31:0] ma [25];
  logic [31:0] mb [25];
  logic [31:0] mexp [25];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mat_mul_check #(.N(5), .DW(32), .FRAC(16), .TOL(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .is_identity(is_identity), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a [25], input logic [31:0] b [25], output int t_last);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    for (int w = 0; w < 50; w++) begin
      in_valid = 1'b1;
      in_data  = (w < 25) ? a[w] : b[w-25];
      step();
    end
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    t_last   = cyc;
  endtask

  task automatic collect(input logic [31:0] exp [25], input bit exp_id, input int stall_idx, input int t_last);
    int prev;
    int waitc;
    logic [31:0] hold_d;
    logic hold_l;
    bit stable;
    prev = t_last;
    out_ready = 1'b1;
    for (int e = 0; e < 25; e++) begin
      waitc = 0;
      while (out_valid !== 1'b1 && waitc < 20) begin
        step();
        waitc++;
      end
      check($sformatf("out_valid_wait[%0d]", e), 64'(out_valid), 64'(1));
      if (out_valid !== 1'b1) return;
      if (e == stall_idx) begin
        out_ready = 1'b0;
        hold_d = out_data;
        hold_l = out_last;
        stable = 1'b1;
        repeat (10) begin
          step();
          if (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l) stable = 1'b0;
        end
        check("stall_stable", 64'(stable), 64'(1));
        out_ready = 1'b1;
      end
      check($sformatf("data[%0d]", e), 64'(out_data), 64'(exp[e]));
      check($sformatf("last[%0d]", e), 64'(out_last), 64'(e == 24));
      check($sformatf("in_ready_busy[%0d]", e), 64'(in_ready), 64'(0));
      if (e == 24) check("is_identity", 64'(is_identity), 64'(exp_id));
      step();
      if (stall_idx < 0) check($sformatf("gap[%0d]", e), 64'(cyc - prev), 64'(6));
      prev = cyc;
    end
    out_ready = 1'b0;
    check("done_in_ready", 64'(in_ready), 64'(1));
    check("done_busy", 64'(busy), 64'(0));
    check("done_out_valid", 64'(out_valid), 64'(0));
  endtask

  initial begin
    int hs;
    int guard;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_is_identity", 64'(is_identity), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    step();

    // A*B = I via a cancelling off-diagonal pair; also checks timing
    for (int i = 0; i < 25; i++) begin
      ma[i]   = (i % 6 == 0) ? 32'h0001_0000 : 32'h0;
      mb[i]   = ma[i];
      mexp[i] = ma[i];
    end
    ma[5] = 32'h0003_0000;
    mb[5] = 32'hFFFD_0000;
    load(ma, mb, t_in);
    collect(mexp, 1'b1, -1, t_in);

    // A = I: C = B, with a 10-cycle stall on element 7
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        ma[r*5+c]   = (r == c) ? 32'h0001_0000 : 32'h0;
        mb[r*5+c]   = (r * 5 + c) << 16;
        mexp[r*5+c] = (r * 5 + c) << 16;
      end
    load(ma, mb, t_in);
    collect(mexp, 1'b0, 7, t_in);

    // Positive overflow clamps to max
    for (int i = 0; i < 25; i++) begin
      ma[i]   = 32'h7FFF_0000;
      mb[i]   = 32'h7FFF_0000;
      mexp[i] = 32'h7FFF_FFFF;
    end
    load(ma, mb, t_in);
    collect(mexp, 1'b0, -1, t_in);

    // A = -I: negative diagonal
    for (int i = 0; i < 25; i++) begin
      ma[i]   = (i % 6 == 0) ? 32'hFFFF_0000 : 32'h0;
      mb[i]   = (i % 6 == 0) ? 32'h0001_0000 : 32'h0;
      mexp[i] = ma[i];
    end
    load(ma, mb, t_in);
    collect(mexp, 1'b0, -1, t_in);

    // Reset while computing element 12, then a clean identity run
    for (int i = 0; i < 25; i++) begin
      ma[i]   = (i % 6 == 0) ? 32'h0001_0000 : 32'h0;
      mb[i]   = ma[i];
      mexp[i] = ma[i];
    end
    load(ma, mb, t_in);
    out_ready = 1'b1;
    hs = 0;
    guard = 0;
    while (hs < 12 && guard < 200) begin
      if (out_valid === 1'b1) hs++;
      step();
      guard++;
    end
    check("mid_run_progress", 64'(hs), 64'(12));
    step();
    check("mid_run_busy", 64'(busy), 64'(1));
    check("mid_run_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("post_rst_out_valid", 64'(out_valid), 64'(0));
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    load(ma, mb, t_in);
    collect(mexp, 1'b1, -1, t_in);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
